mult_wb_arbiter: RTL



---
 rtl/mult_wb_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mult_wb_arbiter.sv
// Writeback arbiter: merges multiplier results with main-pipeline writeback into one RF write port.
// Optional macro MULT_WB_BYPASS_EN enables the direct multiplier-to-RF bypass when the FIFO is empty.
module mult_wb_arbiter #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_mult_ready,
    input  logic [ADDR_W-1:0]            i_mult_rd,
    input  logic [DATA_W-1:0]            i_mult_result,
    input  logic [ADDR_W-1:0]            i_p1_rd,
    input  logic [ADDR_W-1:0]            i_p2_rd,
    input  logic [ADDR_W-1:0]            i_p3_rd,
    input  logic                         i_pipe_we,
    input  logic [ADDR_W-1:0]            i_pipe_rd,
    input  logic [DATA_W-1:0]            i_pipe_data,
    input  logic [ADDR_W-1:0]            i_src_rs,
    input  logic [ADDR_W-1:0]            i_src_rt,
    output logic                         o_rf_we,
    output logic [ADDR_W-1:0]            o_rf_rd,
    output logic [DATA_W-1:0]            o_rf_data,
    output logic                         o_hazard_stall,
    output logic                         o_fifo_full,
    output logic [$clog2(DEPTH+1)-1:0]   o_fifo_count,
    output logic                         o_overflow
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             head;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   slot_off;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic               accept;
    logic               empty;
    logic               full;
    logic               pop;
    logic               bypass;
    logic               push_req;
    logic               push;
    logic               drop;
    logic               hit;

    function automatic logic src_hit(input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt,
                                     input logic [ADDR_W-1:0] rd);
        return ((rs != '0) && (rs == rd)) || ((rt != '0) && (rt == rd));
    endfunction

    // Arbitration: pipe first, then FIFO head, then (optionally) a direct bypass.
    always_comb begin
        accept = i_mult_ready && (i_mult_rd != '0);
        empty  = (count == '0);
        full   = (count == CNT_W'(DEPTH));
        pop    = !i_pipe_we && !empty;
`ifdef MULT_WB_BYPASS_EN
        bypass = !i_pipe_we && empty && accept;
`else
        bypass = 1'b0;
`endif
        push_req   = accept && !bypass;
        push       = push_req && (!full || pop);
        drop       = push_req && full && !pop;
        count_next = count + CNT_W'(push) - CNT_W'(pop);
        head       = mem[rd_ptr];
    end

    // Decode stall: any source still owed a result in flight, queued, or being written.
    always_comb begin
        slot_off = '0;
        hit = src_hit(i_src_rs, i_src_rt, i_p1_rd) ||
              src_hit(i_src_rs, i_src_rt, i_p2_rd) ||
              src_hit(i_src_rs, i_src_rt, i_p3_rd) ||
              (i_mult_ready && src_hit(i_src_rs, i_src_rt, i_mult_rd)) ||
              (o_rf_we && src_hit(i_src_rs, i_src_rt, o_rf_rd));
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot_off = PTR_W'(i) - rd_ptr;
            if ((CNT_W'(slot_off) < count) && src_hit(i_src_rs, i_src_rt, mem[i].rd)) begin
                hit = 1'b1;
            end
        end
        o_hazard_stall = hit;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rf_we     <= 1'b0;
            o_rf_rd     <= '0;
            o_rf_data   <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            o_fifo_full <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            if (i_pipe_we) begin
                o_rf_we   <= 1'b1;
                o_rf_rd   <= i_pipe_rd;
                o_rf_data <= i_pipe_data;
            end else if (!empty) begin
                o_rf_we   <= 1'b1;
                o_rf_rd   <= head.rd;
                o_rf_data <= head.data;
            end else if (bypass) begin
                o_rf_we   <= 1'b1;
                o_rf_rd   <= i_mult_rd;
                o_rf_data <= i_mult_result;
            end else begin
                o_rf_we   <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count       <= count_next;
            o_fifo_full <= (count_next == CNT_W'(DEPTH));
            if (drop) begin
                o_overflow <= 1'b1;
            end
        end
    end

    // Storage is not reset; validity comes from count and the pointers.
    always_ff @(posedge i_clk) begin
        if (!i_rst && push) begin
            mem[wr_ptr] <= '{rd: i_mult_rd, data: i_mult_result};
        end
    end

    assign o_fifo_count = count;

endmodule
